// File: rtl/csr_port_arb.sv
// Purpose: arbitrates the single CSR file port between the execute-stage path (EX) and the trap/return sequencer (TR).
// Latency: grant is combinational in cycle N; the response pulse and read data appear in cycle N+1.
// Backpressure: a requester holds valid until its ready; TR wins contention unless EX is starved; a TR burst locks out EX until tr_last.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   ex_req_* / ex_rsp_* / ex_*    EX request (index, rd/wr enables, write data) and its response pulse and read data
//   tr_req_* / tr_rsp_* / tr_*    TR request (plus tr_last burst marker) and its response pulse and read data
//   csr_*                         CSR file access port; csr_rd_data returns the cycle after a read strobe
module csr_port_arb #(
    parameter int XLEN         = 32,
    parameter int CSR_AW       = 12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ex_req_valid,
    output logic              ex_req_ready,
    input  logic [CSR_AW-1:0] ex_csr_index,
    input  logic              ex_rd_en,
    input  logic              ex_wr_en,
    input  logic [XLEN-1:0]   ex_wr_data,
    output logic              ex_rsp_valid,
    output logic [XLEN-1:0]   ex_rd_data,

    input  logic              tr_req_valid,
    output logic              tr_req_ready,
    input  logic [CSR_AW-1:0] tr_csr_index,
    input  logic              tr_rd_en,
    input  logic              tr_wr_en,
    input  logic [XLEN-1:0]   tr_wr_data,
    input  logic              tr_last,
    output logic              tr_rsp_valid,
    output logic [XLEN-1:0]   tr_rd_data,

    output logic              csr_en,
    output logic [CSR_AW-1:0] csr_index,
    output logic              csr_rd_en,
    output logic              csr_wr_en,
    output logic [XLEN-1:0]   csr_wr_data,
    input  logic [XLEN-1:0]   csr_rd_data
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [0:0]      state;
    logic [0:0]      state_nxt;
    logic [3:0]      starve_cnt;
    logic            starved;
    logic            gnt_ex;
    logic            gnt_tr;

    // Read-data capture: the *_pend_rd flags remember whether the grant one
    // cycle back was a read, and *_rd_q holds the last delivered value so the
    // read data stays stable between responses.
    logic            ex_pend_rd;
    logic            tr_pend_rd;
    logic [XLEN-1:0] ex_rd_q;
    logic [XLEN-1:0] tr_rd_q;

    assign starved = (starve_cnt == LIMIT);

    // Grant and next state. Grants are suppressed while rst is high so
    // nothing reaches the CSR file during reset.
    always_comb begin
        gnt_ex    = 1'b0;
        gnt_tr    = 1'b0;
        state_nxt = state;
        if (!rst) begin
            if (state == ST_LOCK) begin
                gnt_tr = tr_req_valid;
            end else if (tr_req_valid && !starved) begin
                gnt_tr = 1'b1;
            end else if (ex_req_valid) begin
                gnt_ex = 1'b1;
            end else if (tr_req_valid) begin
                gnt_tr = 1'b1;
            end
            // A TR beat without tr_last enters or keeps the lock; the last
            // beat releases it. Gaps (no grant) leave the state untouched.
            if (gnt_tr) begin
                state_nxt = tr_last ? ST_IDLE : ST_LOCK;
            end
        end
    end

    assign ex_req_ready = gnt_ex;
    assign tr_req_ready = gnt_tr;

    // CSR port mux; everything is zero without a grant.
    always_comb begin
        csr_en      = 1'b0;
        csr_index   = '0;
        csr_rd_en   = 1'b0;
        csr_wr_en   = 1'b0;
        csr_wr_data = '0;
        if (gnt_tr) begin
            csr_en      = tr_rd_en | tr_wr_en;
            csr_index   = tr_csr_index;
            csr_rd_en   = tr_rd_en;
            csr_wr_en   = tr_wr_en;
            csr_wr_data = tr_wr_data;
        end else if (gnt_ex) begin
            csr_en      = ex_rd_en | ex_wr_en;
            csr_index   = ex_csr_index;
            csr_rd_en   = ex_rd_en;
            csr_wr_en   = ex_wr_en;
            csr_wr_data = ex_wr_data;
        end
    end

    // csr_rd_data is only valid in the response cycle itself, so it is
    // forwarded straight through then and captured for the following cycles.
    assign ex_rd_data = ex_rsp_valid ? (ex_pend_rd ? csr_rd_data : '0) : ex_rd_q;
    assign tr_rd_data = tr_rsp_valid ? (tr_pend_rd ? csr_rd_data : '0) : tr_rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            starve_cnt   <= '0;
            ex_rsp_valid <= 1'b0;
            tr_rsp_valid <= 1'b0;
            ex_pend_rd   <= 1'b0;
            tr_pend_rd   <= 1'b0;
            ex_rd_q      <= '0;
            tr_rd_q      <= '0;
        end else begin
            state <= state_nxt;

            // Counts in LOCK too, but the saturated value only wins
            // arbitration once back in IDLE.
            if (ex_req_valid && !gnt_ex) begin
                if (!starved) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                starve_cnt <= '0;
            end

            ex_rsp_valid <= gnt_ex;
            tr_rsp_valid <= gnt_tr;
            ex_pend_rd   <= gnt_ex & ex_rd_en;
            tr_pend_rd   <= gnt_tr & tr_rd_en;

            if (ex_rsp_valid) begin
                ex_rd_q <= ex_rd_data;
            end
            if (tr_rsp_valid) begin
                tr_rd_q <= tr_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_csr_port_arb.sv
// Purpose: directed scoreboard bench for csr_port_arb with a small CSR file model.
// Latency: stimulus checks grants and port drive in the grant cycle; the monitor checks responses one cycle later.
// Backpressure: the bench holds each request until the cycle it expects the grant.
module tb_csr_port_arb;

    localparam int XLEN   = 32;
    localparam int CSR_AW = 12;

    typedef struct packed {
        logic              v;
        logic [CSR_AW-1:0] idx;
        logic              rd;
        logic              wr;
        logic [XLEN-1:0]   wd;
        logic              last;
    } req_t;

    localparam int G_NONE = 0;
    localparam int G_EX   = 1;
    localparam int G_TR   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ex_req_valid = 1'b0;
    logic              ex_req_ready;
    logic [CSR_AW-1:0] ex_csr_index = '0;
    logic              ex_rd_en = 1'b0;
    logic              ex_wr_en = 1'b0;
    logic [XLEN-1:0]   ex_wr_data = '0;
    logic              ex_rsp_valid;
    logic [XLEN-1:0]   ex_rd_data;
    logic              tr_req_valid = 1'b0;
    logic              tr_req_ready;
    logic [CSR_AW-1:0] tr_csr_index = '0;
    logic              tr_rd_en = 1'b0;
    logic              tr_wr_en = 1'b0;
    logic [XLEN-1:0]   tr_wr_data = '0;
    logic              tr_last = 1'b0;
    logic              tr_rsp_valid;
    logic [XLEN-1:0]   tr_rd_data;
    logic              csr_en;
    logic [CSR_AW-1:0] csr_index;
    logic              csr_rd_en;
    logic              csr_wr_en;
    logic [XLEN-1:0]   csr_wr_data;
    logic [XLEN-1:0]   csr_rd_data = '0;

    int n_chk  = 0;
    int n_fail = 0;
    logic mon_en = 1'b0;

    logic [XLEN-1:0] ex_q[$];
    logic [XLEN-1:0] tr_q[$];
    logic [XLEN-1:0] csr_mem [0:(1<<CSR_AW)-1];

    csr_port_arb #(.XLEN(XLEN), .CSR_AW(CSR_AW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .ex_req_valid(ex_req_valid), .ex_req_ready(ex_req_ready),
        .ex_csr_index(ex_csr_index), .ex_rd_en(ex_rd_en), .ex_wr_en(ex_wr_en),
        .ex_wr_data(ex_wr_data), .ex_rsp_valid(ex_rsp_valid), .ex_rd_data(ex_rd_data),
        .tr_req_valid(tr_req_valid), .tr_req_ready(tr_req_ready),
        .tr_csr_index(tr_csr_index), .tr_rd_en(tr_rd_en), .tr_wr_en(tr_wr_en),
        .tr_wr_data(tr_wr_data), .tr_last(tr_last),
        .tr_rsp_valid(tr_rsp_valid), .tr_rd_data(tr_rd_data),
        .csr_en(csr_en), .csr_index(csr_index), .csr_rd_en(csr_rd_en),
        .csr_wr_en(csr_wr_en), .csr_wr_data(csr_wr_data), .csr_rd_data(csr_rd_data)
    );

    always #5 clk = ~clk;

    // CSR file model: synchronous write, read data registered for the next cycle.
    always @(posedge clk) begin
        if (csr_en) begin
            if (csr_wr_en) csr_mem[csr_index] <= csr_wr_data;
            if (csr_rd_en) csr_rd_data <= csr_mem[csr_index];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic req_t mk(input logic v, input logic [CSR_AW-1:0] idx, input logic rd,
                                input logic wr, input logic [XLEN-1:0] wd, input logic last);
        req_t r;
        r.v = v; r.idx = idx; r.rd = rd; r.wr = wr; r.wd = wd; r.last = last;
        return r;
    endfunction

    // One clock cycle: drive inputs after the falling edge, check the
    // combinational grant and port drive, and queue the expected response.
    task automatic step(input logic rst_v, input req_t e, input req_t t,
                        input int exp_gnt, input logic [XLEN-1:0] exp_rd);
        req_t src;
        logic [46:0] exp_port;
        @(negedge clk);
        rst          = rst_v;
        ex_req_valid = e.v;  ex_csr_index = e.idx; ex_rd_en = e.rd;
        ex_wr_en     = e.wr; ex_wr_data   = e.wd;
        tr_req_valid = t.v;  tr_csr_index = t.idx; tr_rd_en = t.rd;
        tr_wr_en     = t.wr; tr_wr_data   = t.wd;  tr_last  = t.last;
        #1;
        chk("ex_req_ready", 64'(ex_req_ready), 64'(exp_gnt == G_EX));
        chk("tr_req_ready", 64'(tr_req_ready), 64'(exp_gnt == G_TR));
        src = (exp_gnt == G_TR) ? t : e;
        exp_port = (exp_gnt == G_NONE) ? '0 :
                   {src.rd | src.wr, src.idx, src.rd, src.wr, src.wd};
        chk("csr_port", 64'({csr_en, csr_index, csr_rd_en, csr_wr_en, csr_wr_data}), 64'(exp_port));
        if (exp_gnt == G_EX) ex_q.push_back(exp_rd);
        if (exp_gnt == G_TR) tr_q.push_back(exp_rd);
    endtask

    // Response monitor: every response pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ex_rsp_valid) begin
                if (ex_q.size() == 0) chk("ex_rsp_unexpected", 64'(1), 64'(0));
                else chk("ex_rd_data", 64'(ex_rd_data), 64'(ex_q.pop_front()));
            end
            if (tr_rsp_valid) begin
                if (tr_q.size() == 0) chk("tr_rsp_unexpected", 64'(1), 64'(0));
                else chk("tr_rd_data", 64'(tr_rd_data), 64'(tr_q.pop_front()));
            end
        end
    end

    initial begin
        req_t idle;
        req_t ex_rd300;
        idle     = mk(1'b0, 12'h000, 1'b0, 1'b0, 32'h0, 1'b0);
        ex_rd300 = mk(1'b1, 12'h300, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < (1 << CSR_AW); i++) csr_mem[i] = '0;
        csr_mem[12'h300] = 32'h0000_1888;
        csr_mem[12'h305] = 32'h0000_0100;

        // Reset with both requesters valid: nothing granted.
        step(1'b1, ex_rd300, mk(1'b1, 12'h305, 1'b1, 1'b0, 32'h0, 1'b1), G_NONE, 32'h0);
        mon_en = 1'b1;
        step(1'b1, ex_rd300, mk(1'b1, 12'h305, 1'b1, 1'b0, 32'h0, 1'b1), G_NONE, 32'h0);
        chk("reset_rsp", 64'({ex_rsp_valid, tr_rsp_valid}), 64'(0));
        chk("reset_rd_data", {ex_rd_data, tr_rd_data}, 64'(0));

        // After release TR goes first, then the waiting EX.
        step(1'b0, ex_rd300, mk(1'b1, 12'h305, 1'b1, 1'b0, 32'h0, 1'b1), G_TR, 32'h0000_0100);
        step(1'b0, ex_rd300, idle, G_EX, 32'h0000_1888);
        step(1'b0, idle, idle, G_NONE, 32'h0);

        // EX alone reads 0x300.
        step(1'b0, ex_rd300, idle, G_EX, 32'h0000_1888);
        step(1'b0, idle, idle, G_NONE, 32'h0);

        // Locked 3-beat TR burst with a gap after beat 1; EX waits throughout.
        step(1'b0, mk(1'b1, 12'h341, 1'b1, 1'b0, 32'h0, 1'b0),
             mk(1'b1, 12'h341, 1'b0, 1'b1, 32'h8000_0004, 1'b0), G_TR, 32'h0);
        step(1'b0, mk(1'b1, 12'h341, 1'b1, 1'b0, 32'h0, 1'b0), idle, G_NONE, 32'h0);
        step(1'b0, mk(1'b1, 12'h341, 1'b1, 1'b0, 32'h0, 1'b0),
             mk(1'b1, 12'h342, 1'b0, 1'b1, 32'h0000_000B, 1'b0), G_TR, 32'h0);
        step(1'b0, mk(1'b1, 12'h341, 1'b1, 1'b0, 32'h0, 1'b0),
             mk(1'b1, 12'h300, 1'b0, 1'b1, 32'h0000_1808, 1'b1), G_TR, 32'h0);
        step(1'b0, mk(1'b1, 12'h341, 1'b1, 1'b0, 32'h0, 1'b0), idle, G_EX, 32'h8000_0004);
        step(1'b0, idle, idle, G_NONE, 32'h0);

        // Continuous contention: TR four cycles, EX on the fifth, repeating.
        for (int k = 0; k < 11; k++) begin
            step(1'b0, mk(1'b1, 12'h340, 1'b0, 1'b1, 32'hCAFE_0001, 1'b0),
                 mk(1'b1, 12'h342, 1'b1, 1'b0, 32'h0, 1'b1),
                 (k % 5 == 4) ? G_EX : G_TR,
                 (k % 5 == 4) ? 32'h0 : 32'h0000_000B);
        end
        step(1'b0, idle, idle, G_NONE, 32'h0);

        // EX request with neither read nor write: granted, no strobe, zero data.
        step(1'b0, mk(1'b1, 12'h300, 1'b0, 1'b0, 32'h0, 1'b0), idle, G_EX, 32'h0);
        step(1'b0, idle, idle, G_NONE, 32'h0);

        // Reset right after a non-last TR beat drops the lock.
        step(1'b0, idle, mk(1'b1, 12'h341, 1'b0, 1'b1, 32'h1234_5678, 1'b0), G_TR, 32'h0);
        step(1'b1, idle, mk(1'b1, 12'h342, 1'b0, 1'b1, 32'h0000_0003, 1'b0), G_NONE, 32'h0);
        step(1'b0, ex_rd300, idle, G_EX, 32'h0000_1808);
        step(1'b0, idle, idle, G_NONE, 32'h0);
        step(1'b0, idle, idle, G_NONE, 32'h0);

        chk("ex_q_drained", 64'(ex_q.size()), 64'(0));
        chk("tr_q_drained", 64'(tr_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_port_arb.md
Name: csr_port_arb

Overview:
- Arbitrates the single CSR register-file access port between two requesters.
- Requester EX is the execute-stage CSR instruction path (csrrw/csrrs/csrrc and immediate forms).
- Requester TR is the trap/return sequencer (ecall, ebreak, mret, interrupt entry), which issues multi-beat locked bursts (mepc, mcause, mstatus updates).
- Sits between the execute stage, the trap sequencer and the CSR file. Provides fixed trap priority, burst locking and EX starvation protection.

Parameters:
- XLEN, 32, data width.
- CSR_AW, 12, CSR address width.
- STARVE_LIMIT, 4, consecutive cycles EX may wait in IDLE before it is forced ahead of TR. Legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_req_valid  in  1  EX request present
- ex_req_ready  out  1  EX request granted this cycle
- ex_csr_index  in  CSR_AW  EX CSR address
- ex_rd_en  in  1  EX read
- ex_wr_en  in  1  EX write
- ex_wr_data  in  XLEN  EX write data
- ex_rsp_valid  out  1  EX response pulse
- ex_rd_data  out  XLEN  EX read data
- tr_req_valid  in  1  TR request present
- tr_req_ready  out  1  TR request granted this cycle
- tr_csr_index  in  CSR_AW  TR CSR address
- tr_rd_en  in  1  TR read
- tr_wr_en  in  1  TR write
- tr_wr_data  in  XLEN  TR write data
- tr_last  in  1  final beat of TR burst; 0 = hold lock
- tr_rsp_valid  out  1  TR response pulse
- tr_rd_data  out  XLEN  TR read data
- csr_en  out  1  CSR port access strobe
- csr_index  out  CSR_AW  CSR port address
- csr_rd_en  out  1  CSR port read
- csr_wr_en  out  1  CSR port write
- csr_wr_data  out  XLEN  CSR port write data
- csr_rd_data  in  XLEN  CSR file read data, valid the cycle after csr_en with csr_rd_en

Behaviour:
- Clock/reset: clk only; rst is synchronous, active-high.
- Reset values:
  - FSM = IDLE; starve_cnt = 0.
  - ex_rsp_valid = 0, tr_rsp_valid = 0, ex_rd_data = 0, tr_rd_data = 0.
  - Pending-read flags cleared. Combinational outputs follow from the zeroed state.
- FSM states:
  - IDLE:
    - Grant TR if tr_req_valid and starve_cnt != STARVE_LIMIT.
    - Otherwise grant EX if ex_req_valid.
    - Otherwise grant TR if tr_req_valid (covers starve_cnt == STARVE_LIMIT with EX idle).
    - A TR grant with tr_last=0 moves to LOCK.
  - LOCK:
    - Only TR may be granted; ex_req_ready = 0.
    - A TR grant with tr_last=1 returns to IDLE.
    - TR may leave gaps (tr_req_valid=0) without losing the lock.
- Grant and port drive:
  - Grant is combinational; at most one ready high per cycle.
  - csr_index, csr_rd_en, csr_wr_en and csr_wr_data are muxed from the granted requester.
  - csr_en = granted & (rd_en | wr_en).
  - With no grant, all port outputs are 0.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on cycles where ex_req_valid=1 and EX is not granted, in either state.
  - Clears to 0 when EX is granted or ex_req_valid=0.
  - Saturation only takes effect in IDLE. LOCK always completes first.
- Response timing:
  - A grant in cycle N gives the granted side's rsp_valid = 1 in cycle N+1 only.
  - rd_data (registered) = csr_rd_data in N+1 if that grant had rd_en, else 0.
  - Non-granted side's rd_data holds its previous value; its rsp_valid = 0.
- Request with rd_en=wr_en=0: still granted, and rsp_valid still pulses with rd_data = 0. csr_en stays 0.
- Back-to-back: a new grant is allowed every cycle. A response and a new grant coexist in the same cycle.
- Simultaneous requests:
  - IDLE with both valid: TR wins unless starve_cnt == STARVE_LIMIT.
  - After an EX win, starve_cnt clears and TR wins the next contention.
- Requester stability: a requester holds valid and its fields stable until ready; the arbiter does not check this.
- Reset mid-LOCK: returns to IDLE immediately. Any response pending for the next cycle is dropped (rsp_valid = 0).

Test Plan:
1. rst high 2 cycles with both valids high -> all readys 0, csr_en 0, rsp 0. After release, TR granted first.
2. EX alone: read index 0x300, CSR file returns 0x0000_1888 -> ex_req_ready=1 cycle N, csr_en=1 csr_rd_en=1 csr_index=0x300. In N+1: ex_rsp_valid=1, ex_rd_data=0x0000_1888.
3. TR 3-beat burst, writes to 0x341, 0x342, 0x300 with tr_last on beat 3, and a 1-cycle gap after beat 1; EX valid throughout -> EX never granted during the burst. EX granted the cycle after beat 3.
4. Both valid continuously, TR non-burst (tr_last=1 every beat), STARVE_LIMIT=4 -> TR granted 4 cycles, EX on cycle 5, then TR again. Pattern repeats.
5. EX request with rd_en=wr_en=0 -> granted, csr_en=0, ex_rsp_valid pulses with ex_rd_data=0.
6. rst asserted the cycle after TR beat 1 (tr_last=0) -> tr_rsp_valid=0 the next cycle, FSM IDLE, and a subsequent EX-only request is granted immediately.
